toggle_handshake_rx: RTL

TOGGLE_HANDSHAKE_RX -- requirements
Module: toggle_handshake_rx

---
 rtl/toggle_handshake_rx.sv | 85 ++++++++
 1 files changed

// File: rtl/toggle_handshake_rx.sv
// Receive side of a 2-phase (toggle) handshake: synchronizes req_tgl, captures din into a
// one-word holding register, and answers on ack_tgl. Define TOGGLE_HANDSHAKE_RX_OVERRUN_DETECT_EN for the sticky err flag.
module toggle_handshake_rx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] din,
    output logic              ack_tgl,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic [7:0]        rx_count,
    output logic              err
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   req_d;
    logic                   rx_event;

    assign sync_out = sync[SYNC_STAGES-1];
    assign rx_event = sync_out ^ req_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            req_d <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], req_tgl};
            req_d <= sync_out;
        end
    end

    // rx_event arriving while a word is held is simply ignored here: the word is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            ack_tgl    <= 1'b0;
            rx_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_event) begin
                        dout       <= din;
                        dout_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (dout_valid && dout_ready) begin
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                        ack_tgl    <= ~ack_tgl;
                        rx_count   <= rx_count + 8'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TOGGLE_HANDSHAKE_RX_OVERRUN_DETECT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == WAIT && rx_event) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
